// File: rtl/berger_one_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : berger_one_err_monitor
// Description : Error monitor placed after the 12-bit Berger decoder on the
//               memory read path. Each decoded beat is registered and
//               forwarded with one cycle of latency. Errored beats are logged
//               with a saturating error count and a capture of the first
//               failing address. An interrupt is raised for the
//               scrub/diagnostic controller.
// Revision    : 1.0 - initial release
//
// Ports
//   clk             in   clock, all state on the rising edge
//   rst_n           in   asynchronous active-low reset
//   in_valid        in   decoder beat valid
//   in_addr         in   [ADDR_W] address of the beat
//   in_data         in   [8] decoded data byte
//   in_error        in   decoder error_detected (ignored when !in_valid)
//   clr             in   one-cycle clear of all error state
//   out_valid       out  registered in_valid
//   out_data        out  [8] registered in_data
//   out_error       out  registered in_error & in_valid
//   err_count       out  [CNT_W] saturating count of errored beats
//   first_err_addr  out  [ADDR_W] address of first errored beat since clear
//   first_err_valid out  first_err_addr holds a captured address
//   err_sat         out  err_count is all-ones
//   irq             out  error interrupt
//
// Build option
//   BERGER_ONE_IRQ_THRESH_EN
//     undefined : irq is a one-cycle pulse on each CLEAN->ERRORED transition
//                 and THRESH is unused.
//     defined   : irq is a level. It sets when err_count becomes >= THRESH
//                 and is held until clr or reset.
// ============================================================================
module berger_one_err_monitor #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8,
   parameter int THRESH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [7:0]        in_data,
   input  logic              in_error,
   input  logic              clr,
   output logic              out_valid,
   output logic [7:0]        out_data,
   output logic              out_error,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              first_err_valid,
   output logic              err_sat,
   output logic              irq
);

   typedef enum logic [1:0] {
      CLEAN     = 2'd0,
      ERRORED   = 2'd1,
      SATURATED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // THRESH = 0 is not a meaningful threshold. This empty block only makes
   // an illegal value visible in the elaborated hierarchy.
   if (THRESH < 1) begin : g_thresh_illegal
   end

   state_t            state;
   state_t            base_state;
   state_t            state_nx;
   logic [CNT_W-1:0]  base_cnt;
   logic [CNT_W-1:0]  cnt_nx;
   logic [CNT_W:0]    cnt_sum;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] addr_nx;
   logic              base_fv;
   logic              fv_nx;
   logic              err_beat;
   logic              first_err;

   // A clear is applied first and an error beat in the same cycle is then
   // logged on top of the cleared state. The "base_*" values are the state
   // as seen after the clear.
   always_comb begin
      err_beat   = in_valid & in_error;
      base_state = clr ? CLEAN : state;
      base_cnt   = clr ? '0 : err_count;
      base_addr  = clr ? '0 : first_err_addr;
      base_fv    = clr ? 1'b0 : first_err_valid;

      state_nx   = base_state;
      cnt_nx     = base_cnt;
      addr_nx    = base_addr;
      fv_nx      = base_fv;
      first_err  = 1'b0;

      // The increment is one bit wider so that the carry shows the overflow.
      cnt_sum    = {1'b0, base_cnt} + {{CNT_W{1'b0}}, 1'b1};

      if (err_beat) begin
         case (base_state)
            CLEAN, ERRORED: begin
               cnt_nx   = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
               state_nx = (cnt_nx == CNT_MAX) ? SATURATED : ERRORED;
               if (base_state == CLEAN) begin
                  addr_nx   = in_addr;
                  fv_nx     = 1'b1;
                  first_err = 1'b1;
               end
            end
            SATURATED: begin
               state_nx = SATURATED;
            end
            default: begin
               state_nx = CLEAN;
            end
         endcase
      end
   end

`ifdef BERGER_ONE_IRQ_THRESH_EN
   localparam logic [31:0] THRESH_U = 32'(THRESH);
   logic irq_nx;

   // The comparison is made at 32 bits. A THRESH above the counter range
   // therefore never matches.
   always_comb begin
      irq_nx = ((clr ? 1'b0 : irq) | (32'(cnt_nx) >= THRESH_U));
   end

   // first_err is used only by the pulse interrupt.
   logic unused_first_err;
   assign unused_first_err = first_err;
`else
   logic irq_nx;

   always_comb begin
      irq_nx = first_err;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= CLEAN;
         out_valid       <= 1'b0;
         out_data        <= 8'h00;
         out_error       <= 1'b0;
         err_count       <= '0;
         first_err_addr  <= '0;
         first_err_valid <= 1'b0;
         err_sat         <= 1'b0;
         irq             <= 1'b0;
      end else begin
         state           <= state_nx;
         out_valid       <= in_valid;
         out_data        <= in_data;
         out_error       <= in_error & in_valid;
         err_count       <= cnt_nx;
         first_err_addr  <= addr_nx;
         first_err_valid <= fv_nx;
         err_sat         <= (state_nx == SATURATED);
         irq             <= irq_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_berger_one_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_berger_one_err_monitor
// Description : Directed self-checking bench for berger_one_err_monitor.
//               The DUT uses CNT_W=4 so that saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_berger_one_err_monitor;

`ifdef BERGER_ONE_IRQ_THRESH_EN
   localparam bit THR = 1'b1;
`else
   localparam bit THR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_addr = 8'h00;
   logic [7:0] in_data = 8'h00;
   logic       in_error = 1'b0;
   logic       clr = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_error;
   logic [3:0] err_count;
   logic [7:0] first_err_addr;
   logic       first_err_valid;
   logic       err_sat;
   logic       irq;

   int compared = 0;
   int mismatched = 0;

   berger_one_err_monitor #(.ADDR_W(8), .CNT_W(4), .THRESH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr),
      .in_data(in_data), .in_error(in_error), .clr(clr),
      .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
      .err_count(err_count), .first_err_addr(first_err_addr),
      .first_err_valid(first_err_valid), .err_sat(err_sat), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one beat. Sampling happens 1 time unit after the capturing edge.
   task automatic beat(input logic v, input logic [7:0] a, input logic [7:0] d,
                       input logic e, input logic c);
      in_valid = v; in_addr = a; in_data = d; in_error = e; clr = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_error = 1'b0; clr = 1'b0;
   endtask

   task automatic check_err(input string tag, input logic [3:0] cnt,
                            input logic [7:0] fa, input logic fv, input logic sat);
      check({tag, "_cnt"}, 32'(err_count), 32'(cnt));
      check({tag, "_fa"},  32'(first_err_addr), 32'(fa));
      check({tag, "_fv"},  32'(first_err_valid), 32'(fv));
      check({tag, "_sat"}, 32'(err_sat), 32'(sat));
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ov", 32'(out_valid), 0);
      check("rst_od", 32'(out_data), 0);
      check("rst_oe", 32'(out_error), 0);
      check("rst_irq", 32'(irq), 0);
      check_err("rst", 4'd0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Three clean beats
      for (int i = 0; i < 3; i++) begin
         beat(1'b1, 8'h10 + 8'(i), 8'hA5, 1'b0, 1'b0);
         check("clean_ov", 32'(out_valid), 1);
         check("clean_od", 32'(out_data), 32'hA5);
         check("clean_oe", 32'(out_error), 0);
         check("clean_irq", 32'(irq), 0);
         check_err("clean", 4'd0, 8'h00, 1'b0, 1'b0);
      end
      beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      check("idle_ov", 32'(out_valid), 0);

      // First error captures the address. The pulse build raises irq for one cycle.
      beat(1'b1, 8'h22, 8'h3C, 1'b1, 1'b0);
      check("e1_oe", 32'(out_error), 1);
      check("e1_od", 32'(out_data), 32'h3C);
      check("e1_irq", 32'(irq), THR ? 0 : 1);
      check_err("e1", 4'd1, 8'h22, 1'b1, 1'b0);
      beat(1'b1, 8'h30, 8'h5A, 1'b1, 1'b0);
      check("e2_irq", 32'(irq), 0);
      check_err("e2", 4'd2, 8'h22, 1'b1, 1'b0);

      // in_error without in_valid is ignored
      beat(1'b0, 8'h31, 8'h00, 1'b1, 1'b0);
      check("nv_oe", 32'(out_error), 0);
      check_err("nv", 4'd2, 8'h22, 1'b1, 1'b0);

      // Bring the count to 5
      beat(1'b1, 8'h32, 8'h01, 1'b1, 1'b0);
      beat(1'b1, 8'h33, 8'h02, 1'b1, 1'b0);
      check("c4_irq", 32'(irq), THR ? 1 : 0);
      beat(1'b1, 8'h34, 8'h03, 1'b1, 1'b0);
      check_err("c5", 4'd5, 8'h22, 1'b1, 1'b0);

      // clr together with an error beat: the beat is logged as a fresh first error
      beat(1'b1, 8'h44, 8'h99, 1'b1, 1'b1);
      check("clre_irq", 32'(irq), THR ? 0 : 1);
      check("clre_od", 32'(out_data), 32'h99);
      check_err("clre", 4'd1, 8'h44, 1'b1, 1'b0);

      // clr alone wipes error state but still forwards the beat
      beat(1'b1, 8'h45, 8'h77, 1'b0, 1'b1);
      check("clr_ov", 32'(out_valid), 1);
      check("clr_od", 32'(out_data), 32'h77);
      check("clr_irq", 32'(irq), 0);
      check_err("clr", 4'd0, 8'h00, 1'b0, 1'b0);

      // 20 consecutive errors saturate at 15 without wrapping
      for (int i = 0; i < 20; i++) begin
         beat(1'b1, 8'h50 + 8'(i), 8'(i), 1'b1, 1'b0);
         if (i == 13) check_err("sat14", 4'd14, 8'h50, 1'b1, 1'b0);
         if (i == 14) check_err("sat15", 4'd15, 8'h50, 1'b1, 1'b1);
      end
      check_err("sat_end", 4'd15, 8'h50, 1'b1, 1'b1);
      check("sat_irq", 32'(irq), THR ? 1 : 0);
      beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("satclr_irq", 32'(irq), 0);
      check_err("satclr", 4'd0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset between edges with err_count = 3
      beat(1'b1, 8'h60, 8'h11, 1'b1, 1'b0);
      beat(1'b1, 8'h61, 8'h12, 1'b1, 1'b0);
      in_valid = 1'b1; in_addr = 8'h62; in_data = 8'h13; in_error = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_error = 1'b0;
      check_err("pre_ar", 4'd3, 8'h60, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_ov", 32'(out_valid), 0);
      check("ar_od", 32'(out_data), 0);
      check("ar_oe", 32'(out_error), 0);
      check("ar_irq", 32'(irq), 0);
      check_err("ar", 4'd0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      beat(1'b1, 8'h66, 8'h21, 1'b1, 1'b0);
      check("post_ar_irq", 32'(irq), THR ? 0 : 1);
      check_err("post_ar", 4'd1, 8'h66, 1'b1, 1'b0);

`ifdef BERGER_ONE_IRQ_THRESH_EN
      // Threshold level: errors on alternating cycles, irq rises after the 4th
      beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, 8'h70 + 8'(i), 8'h00, 1'b1, 1'b0);
         check("thr_irq", 32'(irq), (i == 3) ? 1 : 0);
         beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
         check("thr_gap_irq", 32'(irq), (i == 3) ? 1 : 0);
      end
      beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("thr_clr_irq", 32'(irq), 0);
`else
      beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      check("pulse_end_irq", 32'(irq), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Hard time bound so that the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/berger_one_err_monitor.md
# berger_one_err_monitor

- Sits directly downstream of the 12-bit Berger decoder on the memory read path.
- Registers each decoded read beat and forwards it with one cycle of latency.
- Tracks detected errors: saturating error count, capture of the first failing address, and an error interrupt for the scrub/diagnostic controller.
- Software clears all error state with a single-cycle clear pulse.

## Interface
- ADDR_W, 8, width of the read address accompanying each beat
- CNT_W, 8, width of the saturating error counter
- THRESH, 4, error-count interrupt threshold (used only with BERGER_ONE_IRQ_THRESH_EN)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoder beat valid
- in_addr  in  ADDR_W  address of the beat
- in_data  in  8  decoded data byte
- in_error  in  1  decoder error_detected for the beat
- clr  in  1  one-cycle clear of all error state
- out_valid  out  1  registered in_valid
- out_data  out  8  registered in_data
- out_error  out  1  registered in_error & in_valid
- err_count  out  CNT_W  number of errored beats since reset/clr, saturating
- first_err_addr  out  ADDR_W  address of first errored beat since reset/clr
- first_err_valid  out  1  first_err_addr holds a captured address
- err_sat  out  1  err_count reached all-ones
- irq  out  1  error interrupt (see Configuration)

## Operation
- Error beat: in_valid=1 and in_error=1. in_error is ignored when in_valid=0.
- States:
  - CLEAN: no errors logged.
  - ERRORED: at least one error logged, count below max.
  - SATURATED: err_count = 2^CNT_W−1.
- Transitions on an error beat:
  - CLEAN→ERRORED: err_count←1, first_err_addr←in_addr, first_err_valid←1.
  - ERRORED: err_count+1; move to SATURATED when the result is all-ones.
  - SATURATED: no change (no wrap); err_sat=1.
- first_err_addr is frozen after capture; later errors never overwrite it.
- clr from any state: return to CLEAN, err_count←0, first_err_valid←0, first_err_addr←0, irq←0.
- clr with an error beat in the same cycle: clear first, then log the beat. Result is ERRORED with err_count=1 and first_err_addr=in_addr; a CLEAN→ERRORED irq pulse is generated.
- clr does not affect out_valid, out_data or out_error.
- Arithmetic: err_count is unsigned CNT_W bits; increment is computed at CNT_W+1 bits and saturated.
- Data is never modified; errored beats are still forwarded.

## Timing
- Reset values: out_valid=0, out_data=0, out_error=0, err_count=0, first_err_addr=0, first_err_valid=0, err_sat=0, irq=0; state=CLEAN.
- Forward path latency is 1 cycle: beat sampled at edge N appears on out_* after edge N.
- err_count, first_err_*, err_sat and irq update on the same edge as out_*.
- No backpressure: one beat per cycle is accepted, with back-to-back beats supported.
- Asserting rst_n low mid-stream clears everything immediately, without waiting for a clock. The first beat after deassertion is processed normally.

## Configuration
- BERGER_ONE_IRQ_THRESH_EN undefined:
  - irq is a one-cycle pulse on each CLEAN→ERRORED transition.
  - THRESH is unused.
- BERGER_ONE_IRQ_THRESH_EN defined:
  - irq is a level, set on the edge where err_count becomes ≥ THRESH.
  - It is held until clr or reset; there is no first-error pulse.
  - THRESH=0 is illegal; THRESH > 2^CNT_W−1 means irq never asserts.

## Test plan
- Reset, then 3 clean beats (addr 0x10..0x12, data 0xA5) → out_* match 1 cycle later; err_count=0, irq=0, first_err_valid=0.
- Error beats at addr 0x22 then 0x30 → first_err_addr=0x22, err_count=2. Default build: irq high for exactly 1 cycle after the 0x22 beat.
- CNT_W=4, 20 consecutive error beats → err_count stops at 15, err_sat=1, no wrap; the following clr gives 0, err_sat=0.
- clr coincident with an error beat at addr 0x44 while err_count=5 → next cycle err_count=1, first_err_addr=0x44. Default build: irq pulses.
- BERGER_ONE_IRQ_THRESH_EN, THRESH=4, errors on cycles 1,3,5,7 → irq rises after the 4th error beat and holds until clr.
- rst_n pulled low between edges while err_count=3 → all outputs 0 immediately; the first error after release captures a fresh address.
